count_seq_checker: RTL and testbench
====================================

Name: count_seq_checker

Overview:
- Synchronous checker on the consuming side of the team's counters.
- Samples a WIDTH-bit count stream, either the direct ripple-counter output or its inverted copy, and locks onto it.
- Verifies every subsequent sample is exactly one step from the previous one, then reports lock status, error pulses and a saturating error count.
- Placed downstream of the counter/mux path in self-checking benches and in the FPGA top as a health monitor.

Parameters:
- WIDTH, 4, bit width of the checked count stream.
- ERR_CNT_W, 8, width of the saturating error counter.
- LOCK_THRESH, 2, consecutive matching samples needed to enter LOCK (must be 1 or more).
- UNLOCK_THRESH, 3, consecutive mismatching samples in LOCK that force re-acquire (must be 1 or more).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  sample strobe; din is ignored when low.
- dir  input  1  0 = stream increments (direct count); 1 = stream decrements (inverted count).
- din  input  WIDTH  sampled count value.
- clr_err  input  1  synchronous clear of err_cnt.
- locked  output  1  high while in LOCK.
- err  output  1  one-cycle pulse per mismatching sample in LOCK.
- err_cnt  output  ERR_CNT_W  saturating mismatch count.
- expected  output  WIDTH  next expected value, prev ± 1.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - prev, run, bad, err_cnt, expected, locked and err all go to 0.
- Expected value:
  - dir=0: expected = prev+1 mod 2^WIDTH, so F→0 wraps legally.
  - dir=1: expected = prev−1 mod 2^WIDTH, so 0→F wraps legally.
- Every en=1 cycle loads prev with din, whatever the state or result, so the checker follows the actual stream.
- Cycles with en=0 hold all state. err is 0 on those cycles.
- IDLE, on en: go to ACQ, run=0.
- ACQ, on en:
  - If din==expected: run++. When run reaches LOCK_THRESH, go to LOCK with bad=0.
  - Otherwise run=0. No err and no err_cnt change in ACQ.
- LOCK, on en:
  - If din==expected: bad=0.
  - Otherwise: err=1 for the next cycle, err_cnt++ (saturates at all-ones), bad++. When bad reaches UNLOCK_THRESH, go to ACQ with run=0.
- Outputs are registered. locked/err reflect a sample one cycle after the edge that sampled it.
- dir change: any cycle with dir different from the previous cycle's dir re-enters ACQ with run=0, no err. prev still loads if en.
- clr_err together with an error in the same cycle: err_cnt becomes 1 (the clear applies first, then the increment).
- Reset asserted mid-stream: immediate return to IDLE. The first post-reset sample is never an error.

Optional Feature:
- Macro: COUNT_SEQ_CHECKER_STICKY_EN.
- With the macro defined, two extra outputs are added:
  - err_sticky (1 bit): set on the first err, cleared only by reset or clr_err.
  - first_err_val (WIDTH bits): din of that first error, frozen until cleared.
- Without the macro, neither port nor its registers exist. Core behaviour is identical in both builds.

Decomposition:
- Package count_seq_pkg holds:
  - the state enum (IDLE, ACQ, LOCK);
  - default WIDTH/ERR_CNT_W constants;
  - DIR_UP=0 and DIR_DOWN=1.
- One sub-module: count_seq_satcnt, a parameterised saturating counter with inc and sync clr (clr priority then inc). Used for err_cnt.
- run and bad are small inline counters.

Test Plan:
1. Lock and wrap. dir=0, en=1, din 0,1,2,…,F,0,1.
   - locked rises the cycle after sample 2.
   - No err through the F→0 wrap; err_cnt=0.
2. Down stream. dir=1, din F,E,D,…,0,F.
   - locked the cycle after sample D.
   - 0→F wrap gives no err.
3. Single glitch. Locked up-stream 2,3,9,5,6.
   - err pulses after 9 (expected 4) and after 5 (expected A).
   - err_cnt=2, locked stays high.
   - 6 matches and bad returns to 0.
4. Lock loss. Locked, then 3 non-sequential samples 7,1,C.
   - Three err pulses; locked falls after C.
   - Then 3,4 are not errors: 3 (expected D) is a non-error mismatch in ACQ, 4 matches.
   - Relock after 5.
5. Saturation and clear. ERR_CNT_W=2, 5 errors in LOCK (UNLOCK_THRESH raised to 8).
   - err_cnt sticks at 3.
   - clr_err with an error in the same cycle gives 1.
6. Async reset mid-stream and dir toggle.
   - reset low between edges: locked/err_cnt go to 0 immediately.
   - After release, a dir flip while locked drops lock with no err.
   - With COUNT_SEQ_CHECKER_STICKY_EN defined, first_err_val equals the first glitch value (9 in test 3).

Source files
------------

// File: rtl/count_seq_pkg.sv
// Shared types and constants for the count-stream checker.
package count_seq_pkg;

  // Checker acquisition state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_e;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_ERR_CNT_W = 8;

  // Stream direction: direct count increments, inverted copy decrements
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/count_seq_satcnt.sv
// Saturating up-counter with synchronous clear. When clear and increment
// arrive together the clear applies first, so the result is 1.
module count_seq_satcnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear first, then increment unless already at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) cnt_d = '0;
    if (inc_i && (cnt_d != '1)) cnt_d = cnt_d + W'(1);
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/count_seq_checker.sv
// Count-stream checker: locks onto an up or down count stream and flags
// every sample that is not exactly one step from the previous one.
// Optional build macro COUNT_SEQ_CHECKER_STICKY_EN adds err_sticky and
// first_err_val, which capture the value of the first error seen.
module count_seq_checker
  import count_seq_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int ERR_CNT_W     = DEF_ERR_CNT_W,
  parameter int LOCK_THRESH   = 2,
  parameter int UNLOCK_THRESH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 dir,
  input  logic [WIDTH-1:0]     din,
  input  logic                 clr_err,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0]     expected
`ifdef COUNT_SEQ_CHECKER_STICKY_EN
  ,
  output logic                 err_sticky,
  output logic [WIDTH-1:0]     first_err_val
`endif
);

  // Counters must be able to hold their threshold value
  localparam int RUN_W = $clog2(LOCK_THRESH + 1);
  localparam int BAD_W = $clog2(UNLOCK_THRESH + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_THRESH - 1);
  localparam logic [BAD_W-1:0] BAD_LAST = BAD_W'(UNLOCK_THRESH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [BAD_W-1:0] bad_q, bad_d;
  logic             dir_q;
  logic             locked_q, err_q;
  logic             dir_chg, match, err_ev;

  assign dir_chg = (dir != dir_q);
  assign match   = (din == exp_q);

  // Next-state: a direction change always restarts acquisition silently;
  // otherwise only sampled cycles advance the state.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    bad_d   = bad_q;
    err_ev  = 1'b0;
    if (dir_chg) begin
      state_d = ACQ;
      run_d   = '0;
    end else if (en) begin
      case (state_q)
        IDLE: begin
          state_d = ACQ;
          run_d   = '0;
        end
        ACQ: begin
          if (match) begin
            run_d = run_q + RUN_W'(1);
            if (run_q == RUN_LAST) begin
              state_d = LOCK;
              bad_d   = '0;
            end
          end else begin
            run_d = '0;
          end
        end
        LOCK: begin
          if (match) begin
            bad_d = '0;
          end else begin
            err_ev = 1'b1;
            bad_d  = bad_q + BAD_W'(1);
            if (bad_q == BAD_LAST) begin
              state_d = ACQ;
              run_d   = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Track the actual stream and predict its next value in the current dir
  always_comb begin
    prev_d = en ? din : prev_q;
    exp_d  = exp_q;
    if (en || dir_chg)
      exp_d = (dir == DIR_DOWN) ? prev_d - WIDTH'(1) : prev_d + WIDTH'(1);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      exp_q    <= '0;
      run_q    <= '0;
      bad_q    <= '0;
      dir_q    <= DIR_UP;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      exp_q    <= exp_d;
      run_q    <= run_d;
      bad_q    <= bad_d;
      dir_q    <= dir;
      locked_q <= (state_d == LOCK);
      err_q    <= err_ev;
    end
  end

  count_seq_satcnt #(.W(ERR_CNT_W)) u_err_cnt (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (clr_err),
    .inc_i  (err_ev),
    .cnt_o  (err_cnt)
  );

  assign locked   = locked_q;
  assign err      = err_q;
  assign expected = exp_q;

`ifdef COUNT_SEQ_CHECKER_STICKY_EN
  logic             stk_q, stk_d;
  logic [WIDTH-1:0] fev_q, fev_d;

  // Capture the first error after reset or clear; clear applies before set
  always_comb begin
    stk_d = stk_q;
    fev_d = fev_q;
    if (clr_err) begin
      stk_d = 1'b0;
      fev_d = '0;
    end
    if (err_ev && !stk_d) begin
      stk_d = 1'b1;
      fev_d = din;
    end
  end

  // Sticky capture registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stk_q <= 1'b0;
      fev_q <= '0;
    end else begin
      stk_q <= stk_d;
      fev_q <= fev_d;
    end
  end

  assign err_sticky    = stk_q;
  assign first_err_val = fev_q;
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// Self-checking bench for count_seq_checker: two instances (default
// parameters, and a narrow-counter / high-unlock variant) share stimulus
// and are compared against a behavioural model of the checking rules.
module tb_count_seq_checker;

  logic       clk, reset, en, dir, clr_err;
  logic [3:0] din;

  logic       locked_a, err_a, locked_b, err_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [3:0] exp_a, exp_b;
`ifdef COUNT_SEQ_CHECKER_STICKY_EN
  logic       stk_a, stk_b;
  logic [3:0] fev_a, fev_b;
`endif

  int n_vec = 0;
  int n_bad = 0;

  count_seq_checker u_a (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .din(din), .clr_err(clr_err),
    .locked(locked_a), .err(err_a), .err_cnt(cnt_a), .expected(exp_a)
`ifdef COUNT_SEQ_CHECKER_STICKY_EN
    , .err_sticky(stk_a), .first_err_val(fev_a)
`endif
  );

  count_seq_checker #(.WIDTH(4), .ERR_CNT_W(2), .LOCK_THRESH(2), .UNLOCK_THRESH(8)) u_b (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .din(din), .clr_err(clr_err),
    .locked(locked_b), .err(err_b), .err_cnt(cnt_b), .expected(exp_b)
`ifdef COUNT_SEQ_CHECKER_STICKY_EN
    , .err_sticky(stk_b), .first_err_val(fev_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_ACQ = 1, M_LOCK = 2;
  int LT   [2] = '{2, 2};
  int UT   [2] = '{3, 8};
  int CMAX [2] = '{255, 3};
  int m_mode [2];
  int m_run  [2];
  int m_bad  [2];
  int m_cnt  [2];
  bit m_err  [2];
  bit m_stk  [2];
  int m_fev  [2];
  int m_prev, m_exp;
  bit m_dir;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_IDLE; m_run[i] = 0; m_bad[i] = 0; m_cnt[i] = 0;
      m_err[i] = 0; m_stk[i] = 0; m_fev[i] = 0;
    end
    m_prev = 0; m_exp = 0; m_dir = 0;
  endfunction

  function automatic void model_step(bit e, bit d, int v, bit c);
    bit chg;
    int ex_old;
    chg = (d != m_dir);
    ex_old = m_exp;
    m_dir = d;
    for (int i = 0; i < 2; i++) begin
      bit ev;
      ev = 0;
      if (chg) begin
        m_mode[i] = M_ACQ; m_run[i] = 0;
      end else if (e) begin
        if (m_mode[i] == M_IDLE) begin
          m_mode[i] = M_ACQ; m_run[i] = 0;
        end else if (m_mode[i] == M_ACQ) begin
          if (v == ex_old) begin
            m_run[i]++;
            if (m_run[i] >= LT[i]) begin m_mode[i] = M_LOCK; m_bad[i] = 0; end
          end else m_run[i] = 0;
        end else begin
          if (v == ex_old) m_bad[i] = 0;
          else begin
            ev = 1;
            m_bad[i]++;
            if (m_bad[i] >= UT[i]) begin m_mode[i] = M_ACQ; m_run[i] = 0; end
          end
        end
      end
      if (c) begin m_cnt[i] = 0; m_stk[i] = 0; m_fev[i] = 0; end
      if (ev && m_cnt[i] < CMAX[i]) m_cnt[i]++;
      if (ev && !m_stk[i]) begin m_stk[i] = 1; m_fev[i] = v; end
      m_err[i] = ev;
    end
    if (e) m_prev = v;
    if (e || chg) m_exp = d ? (m_prev + 15) % 16 : (m_prev + 1) % 16;
  endfunction

  function automatic bit m_lock(int i);
    return m_mode[i] == M_LOCK;
  endfunction

  // One clock of stimulus; returns at the following falling edge
  task automatic cyc(input bit e, input bit d, input logic [3:0] v, input bit c);
    en = e; dir = d; din = v; clr_err = c;
    @(posedge clk);
    model_step(e, d, int'(v), c);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; en = 0; dir = 0; din = 0; clr_err = 0;
    model_reset();
    repeat (2) @(negedge clk);
    n_vec++; if (locked_a !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b want 0", locked_a); end
    n_vec++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_a); end
    n_vec++; if (cnt_a !== 8'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", cnt_a); end
    n_vec++; if (exp_a !== 4'd0) begin n_bad++; $display("FAIL reset_expected: got %0d want 0", exp_a); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lock_wrap();
    for (int k = 0; k < 18; k++) begin
      cyc(1, 0, 4'(k), 0);
      n_vec++; if (locked_a !== (k >= 2)) begin n_bad++; $display("FAIL wrap_locked[%0d]: got %b want %b", k, locked_a, (k >= 2)); end
      n_vec++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL wrap_err[%0d]: got %b want 0", k, err_a); end
      n_vec++; if (exp_a !== 4'(m_exp)) begin n_bad++; $display("FAIL wrap_expected[%0d]: got %0d want %0d", k, exp_a, m_exp); end
    end
    n_vec++; if (cnt_a !== 8'd0) begin n_bad++; $display("FAIL wrap_cnt: got %0d want 0", cnt_a); end
  endtask

  task automatic test_down();
    for (int k = 0; k < 17; k++) begin
      cyc(1, 1, 4'(15 - k), 0);
      n_vec++; if (locked_a !== (k >= 2)) begin n_bad++; $display("FAIL down_locked[%0d]: got %b want %b", k, locked_a, (k >= 2)); end
      n_vec++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL down_err[%0d]: got %b want 0", k, err_a); end
      n_vec++; if (exp_a !== 4'(m_exp)) begin n_bad++; $display("FAIL down_expected[%0d]: got %0d want %0d", k, exp_a, m_exp); end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] seq [0:6];
    seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd9, 4'd5, 4'd6};
    for (int k = 0; k < 7; k++) begin
      cyc(1, 0, seq[k], 0);
      n_vec++; if (err_a !== (k == 4 || k == 5)) begin n_bad++; $display("FAIL glitch_err[%0d]: got %b want %b", k, err_a, (k == 4 || k == 5)); end
      n_vec++; if (locked_a !== m_lock(0)) begin n_bad++; $display("FAIL glitch_locked[%0d]: got %b want %b", k, locked_a, m_lock(0)); end
    end
    n_vec++; if (locked_a !== 1'b1) begin n_bad++; $display("FAIL glitch_still_locked: got %b want 1", locked_a); end
    n_vec++; if (cnt_a !== 8'd2) begin n_bad++; $display("FAIL glitch_cnt: got %0d want 2", cnt_a); end
`ifdef COUNT_SEQ_CHECKER_STICKY_EN
    n_vec++; if (stk_a !== 1'b1) begin n_bad++; $display("FAIL glitch_sticky: got %b want 1", stk_a); end
    n_vec++; if (fev_a !== 4'd9) begin n_bad++; $display("FAIL glitch_first_err_val: got %0d want 9", fev_a); end
`endif
  endtask

  task automatic test_lock_loss();
    logic [3:0] seq [0:8];
    seq = '{4'd0, 4'd1, 4'd2, 4'd7, 4'd1, 4'd12, 4'd3, 4'd4, 4'd5};
    // bounce dir with no samples to restart acquisition cleanly
    cyc(0, 1, 4'd0, 0);
    cyc(0, 0, 4'd0, 0);
    n_vec++; if (locked_a !== 1'b0) begin n_bad++; $display("FAIL loss_dir_bounce: got %b want 0", locked_a); end
    for (int k = 0; k < 9; k++) begin
      cyc(1, 0, seq[k], 0);
      n_vec++; if (err_a !== (k >= 3 && k <= 5)) begin n_bad++; $display("FAIL loss_err[%0d]: got %b want %b", k, err_a, (k >= 3 && k <= 5)); end
      n_vec++; if (locked_a !== ((k >= 2 && k <= 4) || k == 8)) begin n_bad++; $display("FAIL loss_locked[%0d]: got %b want %b", k, locked_a, ((k >= 2 && k <= 4) || k == 8)); end
      n_vec++; if (cnt_a !== 8'(m_cnt[0])) begin n_bad++; $display("FAIL loss_cnt[%0d]: got %0d want %0d", k, cnt_a, m_cnt[0]); end
    end
  endtask

  task automatic test_saturation();
    cyc(0, 0, 4'd0, 1);
    n_vec++; if (cnt_b !== 2'd0) begin n_bad++; $display("FAIL sat_clear: got %0d want 0", cnt_b); end
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 4'd9, 0);
      n_vec++; if (err_b !== 1'b1) begin n_bad++; $display("FAIL sat_err[%0d]: got %b want 1", k, err_b); end
      n_vec++; if (cnt_b !== 2'(m_cnt[1])) begin n_bad++; $display("FAIL sat_cnt_b[%0d]: got %0d want %0d", k, cnt_b, m_cnt[1]); end
      n_vec++; if (cnt_a !== 8'(m_cnt[0])) begin n_bad++; $display("FAIL sat_cnt_a[%0d]: got %0d want %0d", k, cnt_a, m_cnt[0]); end
    end
    n_vec++; if (cnt_b !== 2'd3) begin n_bad++; $display("FAIL sat_stuck: got %0d want 3", cnt_b); end
    n_vec++; if (locked_b !== 1'b1) begin n_bad++; $display("FAIL sat_locked_b: got %b want 1", locked_b); end
    cyc(1, 0, 4'd9, 1);
    n_vec++; if (cnt_b !== 2'd1) begin n_bad++; $display("FAIL sat_clr_with_err: got %0d want 1", cnt_b); end
    n_vec++; if (cnt_a !== 8'(m_cnt[0])) begin n_bad++; $display("FAIL sat_clr_a: got %0d want %0d", cnt_a, m_cnt[0]); end
  endtask

  task automatic test_async_reset_dir();
    logic [3:0] seq [0:4];
    seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd9};
    for (int k = 0; k < 5; k++) cyc(1, 0, seq[k], 0);
    n_vec++; if (cnt_a === 8'd0 || locked_a !== 1'b1) begin n_bad++; $display("FAIL pre_reset_state: got cnt=%0d locked=%b want cnt>0 locked=1", cnt_a, locked_a); end
    #1 reset = 1'b0;
    #1;
    model_reset();
    n_vec++; if (locked_a !== 1'b0) begin n_bad++; $display("FAIL async_locked: got %b want 0", locked_a); end
    n_vec++; if (cnt_a !== 8'd0) begin n_bad++; $display("FAIL async_cnt: got %0d want 0", cnt_a); end
    n_vec++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL async_err: got %b want 0", err_a); end
    #1 reset = 1'b1;
    @(negedge clk);
    cyc(1, 0, 4'd5, 0);
    n_vec++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL post_reset_first: got %b want 0", err_a); end
    cyc(1, 0, 4'd6, 0);
    cyc(1, 0, 4'd7, 0);
    n_vec++; if (locked_a !== 1'b1) begin n_bad++; $display("FAIL post_reset_relock: got %b want 1", locked_a); end
    cyc(1, 1, 4'd8, 0);
    n_vec++; if (locked_a !== 1'b0) begin n_bad++; $display("FAIL dir_flip_locked: got %b want 0", locked_a); end
    n_vec++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL dir_flip_err: got %b want 0", err_a); end
    n_vec++; if (exp_a !== 4'd7) begin n_bad++; $display("FAIL dir_flip_expected: got %0d want 7", exp_a); end
  endtask

  task automatic test_random();
    bit e, d, c;
    logic [3:0] v;
    d = m_dir;
    for (int k = 0; k < 400; k++) begin
      e = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 40) == 0) d = ~d;
      if ($urandom_range(0, 9) == 0) v = 4'($urandom);
      else v = d ? 4'(m_prev + 15) : 4'(m_prev + 1);
      c = ($urandom_range(0, 30) == 0);
      cyc(e, d, v, c);
      n_vec++; if (locked_a !== m_lock(0) || err_a !== m_err[0] || cnt_a !== 8'(m_cnt[0]) || exp_a !== 4'(m_exp))
        begin n_bad++; $display("FAIL rand_a[%0d]: got l=%b e=%b c=%0d x=%0d want l=%b e=%b c=%0d x=%0d", k, locked_a, err_a, cnt_a, exp_a, m_lock(0), m_err[0], m_cnt[0], m_exp); end
      n_vec++; if (locked_b !== m_lock(1) || err_b !== m_err[1] || cnt_b !== 2'(m_cnt[1]) || exp_b !== 4'(m_exp))
        begin n_bad++; $display("FAIL rand_b[%0d]: got l=%b e=%b c=%0d x=%0d want l=%b e=%b c=%0d x=%0d", k, locked_b, err_b, cnt_b, exp_b, m_lock(1), m_err[1], m_cnt[1], m_exp); end
`ifdef COUNT_SEQ_CHECKER_STICKY_EN
      n_vec++; if (stk_a !== m_stk[0] || fev_a !== 4'(m_fev[0]) || stk_b !== m_stk[1] || fev_b !== 4'(m_fev[1]))
        begin n_bad++; $display("FAIL rand_sticky[%0d]: got %b/%0d %b/%0d want %b/%0d %b/%0d", k, stk_a, fev_a, stk_b, fev_b, m_stk[0], m_fev[0], m_stk[1], m_fev[1]); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_lock_wrap();
    test_down();
    test_glitch();
    test_lock_loss();
    test_saturation();
    test_async_reset_dir();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
